// File: rtl/aes_pkg.sv
// Shared AES definitions: inverse S-box, GF(2^8) helpers,
// state byte indexing and the decrypt FSM encoding.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } aes_fsm_e;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the low nibble of c is used: 09/0b/0d/0e fit in 4 bits.
  function automatic logic [7:0] gf_mul(input logic [7:0] b,
                                        input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ a;
      a = gf_xtime(a);
    end
    return p;
  endfunction

  // MSB bit of state byte (row r, column c); byte 0 at [127:120].
  function automatic int bpos(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One AES inverse round, purely combinational:
// InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns.
module aes_inv_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  input  logic [127:0] round_key,
  input  logic         is_final,
  output logic [127:0] data_out
);

  logic [127:0] sub;
  logic [127:0] ark;
  logic [127:0] mix;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    {a0, a1, a2, a3} = w;
    o0 = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb)
       ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
    o1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he)
       ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
    o2 = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9)
       ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
    o3 = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd)
       ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    return {o0, o1, o2, o3};
  endfunction

  // Row r rotates right by r: out[r][c] takes in[r][c-r].
  always_comb begin
    sub = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sub[bpos(r, c) -: 8] =
          inv_sbox(data_in[bpos(r, (c + 4 - r) % 4) -: 8]);
      end
    end
  end

  assign ark = sub ^ round_key;

  // Column-wise InvMixColumns; columns are contiguous 32-bit words.
  always_comb begin
    mix = '0;
    for (int c = 0; c < 4; c++) begin
      mix[127 - 32 * c -: 32] = inv_mix_col(ark[127 - 32 * c -: 32]);
    end
  end

  assign data_out = is_final ? ark : mix;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: one inverse round per clock,
// round keys fetched from an external key-store by index.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (NUM_ROUNDS != AES_NR) begin : g_bad_nr
    $error("aes_inv_cipher_iter: only NUM_ROUNDS=10 is supported");
  end

  localparam logic [3:0] RK_LAST = 4'(AES_NR);

  aes_fsm_e     fsm_q;
  logic [127:0] state_q;
  logic [127:0] state_d;
  logic [3:0]   round_q;
  logic         in_ready_q;
  logic         out_valid_q;

  aes_inv_round_comb u_round (
    .data_in   (state_q),
    .round_key (rk_data),
    .is_final  (round_q == 4'd0),
    .data_out  (state_d)
  );

  // Control FSM, round counter and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_q     <= RK_LAST;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= in_data ^ rk_data;
            round_q    <= RK_LAST - 4'd1;
            in_ready_q <= 1'b0;
            fsm_q      <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          state_q <= state_d;
          if (round_q == 4'd0) begin
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            round_q <= round_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            round_q     <= RK_LAST;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = state_q;
  assign rk_idx    = round_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using the
// FIPS-197 C.1 AES-128 vector and its key schedule.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic [127:0] rk [0:10];

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rk_data = (rk_idx > 4'd10) ? '0 : rk[rk_idx];

  aes_inv_cipher_iter #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int nout;
    int acc[$];
    int gap;
    bit seen;

    rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick;
    tick;

    // reset state
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd10);

    rst = 1'b0;
    tick;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // idle input
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid !== 1'b0 || rk_idx !== 4'd10 ||
          in_ready !== 1'b1 || out_data !== '0) bad++;
      tick;
    end
    chk("idle_stable", 128'(bad), 128'd0);

    // C.1 vector with rk_idx sequence and latency
    in_valid = 1'b1;
    in_data = CT;
    chk("acc_rk_idx", 128'(rk_idx), 128'd10);
    tick;
    in_valid = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      chk($sformatf("rk_idx_%0d", k), 128'(rk_idx), 128'(k));
      chk($sformatf("ov_low_%0d", k), 128'(out_valid), 128'd0);
      tick;
    end
    chk("lat_out_valid", 128'(out_valid), 128'd1);
    chk("c1_out_data", out_data, PT);

    // backpressure
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_data !== PT ||
          in_ready !== 1'b0) bad++;
      tick;
    end
    chk("bp_hold", 128'(bad), 128'd0);
    out_ready = 1'b1;
    chk("bp_ov_at_hs", 128'(out_valid), 128'd1);
    tick;
    out_ready = 1'b0;
    chk("hs_in_ready", 128'(in_ready), 128'd1);
    chk("hs_out_valid", 128'(out_valid), 128'd0);
    chk("hs_rk_idx", 128'(rk_idx), 128'd10);

    // back-to-back
    in_valid = 1'b1;
    in_data = CT;
    out_ready = 1'b1;
    nout = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        chk($sformatf("b2b_data_%0d", nout), out_data, PT);
        nout++;
      end
      if (in_valid && in_ready) acc.push_back(cyc);
      tick;
      if (acc.size() == 2) in_valid = 1'b0;
      if (nout == 2) break;
    end
    chk("b2b_nout", 128'(nout), 128'd2);
    chk("b2b_nacc", 128'(acc.size()), 128'd2);
    gap = (acc.size() == 2) ? acc[1] - acc[0] : -1;
    chk("b2b_gap", 128'(gap), 128'd12);
    in_valid = 1'b0;

    // reset mid-operation
    in_valid = 1'b1;
    in_data = CT;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rk_idx == 4'd5) break;
      tick;
    end
    chk("mid_at_5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    tick;
    chk("mid_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rk_idx", 128'(rk_idx), 128'd10);
    rst = 1'b0;
    tick;
    chk("mid_in_ready", 128'(in_ready), 128'd1);

    // fresh block after abort
    in_valid = 1'b1;
    in_data = CT;
    tick;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    chk("fresh_seen", 128'(seen), 128'd1);
    chk("fresh_data", out_data, PT);
    tick;
    chk("fresh_done", 128'(out_valid), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
